// File: rtl/blinky_pkg.sv
// Shared types and widths for the multi-channel LED driver.
package blinky_pkg;

    // Config payload fields are sized for the widest supported channel (CounterWidth <= 32, CountWidth <= 16).
    localparam int unsigned CfgHalfWidth  = 32;
    localparam int unsigned CfgCountWidth = 16;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e                    mode;
        logic [CfgHalfWidth-1:0]  half_period;
        logic [CfgCountWidth-1:0] count;
    } chan_cfg_t;

    // Width of the channel index port; never narrower than one bit.
    function automatic int unsigned chan_width(input int unsigned num_leds);
        return (num_leds > 1) ? $clog2(num_leds) : 1;
    endfunction

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: half-period counter, blink phase and burst sequencing.
module blinky_channel
    import blinky_pkg::*;
#(
    parameter int unsigned CounterWidth      = 24,
    parameter int unsigned CountWidth        = 8,
    parameter int unsigned DefaultHalfPeriod = 12_000_000
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      load_i,
    input  chan_cfg_t cfg_i,
    output logic      led_o,
    output logic      busy_o
);

    mode_e                   mode_q;
    logic [CounterWidth-1:0] half_q;
    logic [CounterWidth-1:0] cnt_q;
    logic [CountWidth-1:0]   rem_q;
    logic                    phase_q;
    logic                    led_q;
    logic                    busy_q;

    logic [CounterWidth-1:0] cnt_d;
    logic [CounterWidth-1:0] cfg_half_d;
    logic [CountWidth-1:0]   cfg_count_d;
    mode_e                   cfg_mode_d;
    logic                    at_term;

    // Counter wrap detection and sanitised incoming config (H=0 -> 1, empty burst -> OFF).
    always_comb begin
        at_term     = (cnt_q == (half_q - CounterWidth'(1)));
        cnt_d       = at_term ? '0 : (cnt_q + CounterWidth'(1));
        cfg_half_d  = CounterWidth'(cfg_i.half_period);
        cfg_count_d = CountWidth'(cfg_i.count);
        cfg_mode_d  = cfg_i.mode;
        if (cfg_half_d == '0) begin
            cfg_half_d = CounterWidth'(1);
        end
        if ((cfg_i.mode == MODE_BURST) && (cfg_count_d == '0)) begin
            cfg_mode_d = MODE_OFF;
        end
    end

    // Mode FSM; outputs hold on the load edge and reflect the new config from the next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_OFF;
            half_q  <= CounterWidth'(DefaultHalfPeriod);
            cnt_q   <= '0;
            rem_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (load_i) begin
            mode_q  <= cfg_mode_d;
            half_q  <= cfg_half_d;
            cnt_q   <= '0;
            rem_q   <= cfg_count_d;
            phase_q <= 1'b1;
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    led_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                MODE_ON: begin
                    led_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                MODE_BLINK: begin
                    led_q  <= phase_q;
                    busy_q <= 1'b0;
                    cnt_q  <= cnt_d;
                    if (at_term) begin
                        phase_q <= ~phase_q;
                    end
                end
                MODE_BURST: begin
                    led_q  <= phase_q;
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_d;
                    if (at_term) begin
                        phase_q <= ~phase_q;
                        // End of an on-phase: one pulse done; the last one drops the channel to OFF.
                        if (phase_q) begin
                            rem_q <= rem_q - CountWidth'(1);
                            if (rem_q == CountWidth'(1)) begin
                                mode_q <= MODE_OFF;
                            end
                        end
                    end
                end
                default: begin
                    led_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/blinky_multi.sv
// Multi-channel LED driver: config decode, ready handshake and per-channel instances.
module blinky_multi
    import blinky_pkg::*;
#(
    parameter int unsigned NumLeds           = 4,
    parameter int unsigned CounterWidth      = 24,
    parameter int unsigned DefaultHalfPeriod = 12_000_000,
    parameter int unsigned CountWidth        = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [chan_width(NumLeds)-1:0]  cfg_chan_i,
    input  logic [1:0]                      cfg_mode_i,
    input  logic [CounterWidth-1:0]         cfg_half_period_i,
    input  logic [CountWidth-1:0]           cfg_count_i,
    output logic [NumLeds-1:0]              led_o,
    output logic [NumLeds-1:0]              busy_o
);

    localparam int unsigned ChanWidth = chan_width(NumLeds);

    logic      ready_q;
    logic      accept;
    chan_cfg_t cfg_c;

    // Ready is low only in cycles following a reset edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Pack the request into the shared config payload.
    always_comb begin
        accept            = cfg_valid_i & ready_q;
        cfg_c.mode        = mode_e'(cfg_mode_i);
        cfg_c.half_period = CfgHalfWidth'(cfg_half_period_i);
        cfg_c.count       = CfgCountWidth'(cfg_count_i);
    end

    // Out-of-range indices match no channel and are silently dropped.
    for (genvar g = 0; g < NumLeds; g++) begin : g_chan
        blinky_channel #(
            .CounterWidth      (CounterWidth),
            .CountWidth        (CountWidth),
            .DefaultHalfPeriod (DefaultHalfPeriod)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .load_i (accept && (cfg_chan_i == ChanWidth'(g))),
            .cfg_i  (cfg_c),
            .led_o  (led_o[g]),
            .busy_o (busy_o[g])
        );
    end

    assign cfg_ready_o = ready_q;

endmodule

// File: tb/tb_blinky_multi.sv
// Self-checking bench for blinky_multi: per-cycle reference model plus literal waveform checks.
module tb_blinky_multi;

    localparam int NL = 5;   // 5 channels gives a 3-bit index, so indices 5..7 are out of range
    localparam int CW = 24;
    localparam int NW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [2:0]    cfg_chan_i;
    logic [1:0]    cfg_mode_i;
    logic [CW-1:0] cfg_half_period_i;
    logic [NW-1:0] cfg_count_i;
    logic [NL-1:0] led_o;
    logic [NL-1:0] busy_o;

    blinky_multi #(
        .NumLeds           (NL),
        .CounterWidth      (CW),
        .DefaultHalfPeriod (12_000_000),
        .CountWidth        (NW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cfg_valid_i       (cfg_valid_i),
        .cfg_ready_o       (cfg_ready_o),
        .cfg_chan_i        (cfg_chan_i),
        .cfg_mode_i        (cfg_mode_i),
        .cfg_half_period_i (cfg_half_period_i),
        .cfg_count_i       (cfg_count_i),
        .led_o             (led_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel remembers when it was configured and derives its
    // waveform from the elapsed edge count k (k=1 is the first edge after acceptance).
    longint        edge_n = 0;
    longint        m_t    [NL];
    int            m_mode [NL];
    longint        m_h    [NL];
    longint        m_n    [NL];
    logic [NL-1:0] exp_led   = '0;
    logic [NL-1:0] exp_busy  = '0;
    logic          exp_ready = 1'b0;
    bit            started   = 1'b0;

    initial begin
        for (int i = 0; i < NL; i++) begin
            m_t[i] = 0; m_mode[i] = 0; m_h[i] = 1; m_n[i] = 0;
        end
        forever begin
            @(posedge clk_i);
            edge_n++;
            started = 1'b1;
            if (rst_i) begin
                for (int i = 0; i < NL; i++) m_mode[i] = 0;
                exp_led   = '0;
                exp_busy  = '0;
                exp_ready = 1'b0;
            end else begin
                bit acc;
                acc = cfg_valid_i && exp_ready && (int'(cfg_chan_i) < NL);
                for (int i = 0; i < NL; i++) begin
                    if (!(acc && int'(cfg_chan_i) == i)) begin
                        longint k;
                        k = edge_n - m_t[i];
                        case (m_mode[i])
                            1: begin exp_led[i] = 1'b1; exp_busy[i] = 1'b0; end
                            2: begin
                                exp_led[i]  = (((k - 1) / m_h[i]) % 2) == 0;
                                exp_busy[i] = 1'b0;
                            end
                            3: begin
                                exp_busy[i] = (m_n[i] > 0) && (k <= (2 * m_n[i] - 1) * m_h[i]);
                                exp_led[i]  = exp_busy[i] && ((((k - 1) / m_h[i]) % 2) == 0);
                            end
                            default: begin exp_led[i] = 1'b0; exp_busy[i] = 1'b0; end
                        endcase
                    end
                end
                if (acc) begin
                    int c;
                    c = int'(cfg_chan_i);
                    m_t[c]    = edge_n;
                    m_mode[c] = int'(cfg_mode_i);
                    m_h[c]    = (cfg_half_period_i == '0) ? 1 : longint'(cfg_half_period_i);
                    m_n[c]    = longint'(cfg_count_i);
                end
                exp_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (started) begin
                chk("model_led",   32'(led_o),       32'(exp_led));
                chk("model_busy",  32'(busy_o),      32'(exp_busy));
                chk("model_ready", 32'(cfg_ready_o), 32'(exp_ready));
            end
        end
    end

    // Present one config at a negedge; it is accepted on the following posedge.
    task automatic cfg(input int chan, input int mode, input int h, input int n);
        cfg_valid_i       = 1'b1;
        cfg_chan_i        = 3'(chan);
        cfg_mode_i        = 2'(mode);
        cfg_half_period_i = CW'(h);
        cfg_count_i       = NW'(n);
        @(negedge clk_i);
        cfg_valid_i       = 1'b0;
    endtask

    initial begin
        logic [8:0] blink_pat;
        logic [7:0] burst_led;
        logic [7:0] burst_busy;
        logic [3:0] fast_pat;
        blink_pat  = 9'b111000111;
        burst_led  = 8'b11001100;
        burst_busy = 8'b11111100;
        fast_pat   = 4'b1010;

        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_chan_i = '0;
        cfg_mode_i = '0; cfg_half_period_i = '0; cfg_count_i = '0;

        // Reset held for three edges, then released.
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(cfg_ready_o), 32'd0);
        chk("rst_led",   32'(led_o),       32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_up", 32'(cfg_ready_o), 32'd1);

        // BLINK ch0, H=3.
        cfg(0, 2, 3, 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            chk("blink_h3", 32'(led_o[0]), 32'(blink_pat[9 - k]));
        end
        chk("blink_others", 32'(led_o[NL-1:1]), 32'd0);

        // BURST ch1, H=2, N=2.
        cfg(1, 3, 2, 2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            chk("burst_led",  32'(led_o[1]),  32'(burst_led[8 - k]));
            chk("burst_busy", 32'(busy_o[1]), 32'(burst_busy[8 - k]));
        end

        // Reconfigure ch2 to ON in the middle of a burst.
        cfg(2, 3, 4, 5);
        repeat (5) @(negedge clk_i);
        cfg(2, 1, 0, 0);
        chk("abort_hold_busy", 32'(busy_o[2]), 32'd1);
        chk("abort_hold_led",  32'(led_o[2]),  32'd0);
        @(negedge clk_i);
        chk("abort_on_led",  32'(led_o[2]),  32'd1);
        chk("abort_on_busy", 32'(busy_o[2]), 32'd0);
        repeat (3) @(negedge clk_i);
        chk("abort_steady", 32'(led_o[2]), 32'd1);

        // H=0 behaves as H=1: toggles every cycle.
        cfg(3, 2, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            chk("blink_h0", 32'(led_o[3]), 32'(fast_pat[4 - k]));
        end

        // BURST with N=0 acts as OFF.
        cfg(4, 1, 0, 0);
        @(negedge clk_i);
        chk("n0_pre_on", 32'(led_o[4]), 32'd1);
        cfg(4, 3, 5, 0);
        @(negedge clk_i);
        chk("n0_led",  32'(led_o[4]),  32'd0);
        chk("n0_busy", 32'(busy_o[4]), 32'd0);

        // Out-of-range channels are accepted and ignored.
        cfg(7, 1, 0, 0);
        chk("oor_ready", 32'(cfg_ready_o), 32'd1);
        cfg(5, 1, 0, 0);
        cfg(6, 3, 2, 3);
        repeat (4) @(negedge clk_i);
        chk("oor_led4",  32'(led_o[4]),  32'd0);
        chk("oor_busy",  32'(busy_o),    32'd0);

        // Reset in the middle of activity.
        for (int i = 0; i < NL; i++) cfg(i, 2, 2, 0);
        cfg(1, 3, 3, 4);
        repeat (3) @(negedge clk_i);
        chk("pre_rst_busy", 32'(busy_o[1]), 32'd1);
        rst_i       = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_chan_i  = 3'd0;
        cfg_mode_i  = 2'd1;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        chk("midrst_led",   32'(led_o),       32'd0);
        chk("midrst_busy",  32'(busy_o),      32'd0);
        chk("midrst_ready", 32'(cfg_ready_o), 32'd0);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("postrst_led",   32'(led_o),       32'd0);
        chk("postrst_busy",  32'(busy_o),      32'd0);
        chk("postrst_ready", 32'(cfg_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
